seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller.
// Each slot drives one digit for CLK_DIV cycles and then blanks every digit
// for BLANK_CYC cycles. A double-buffered frame store (pending/active) makes
// sure a new frame is only shown from a frame boundary onwards.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  output logic [7:0]  seg_led,
  output logic [7:0]  digtal_sw,
  output logic        frame_done
);

  localparam int MAXC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {
    DISP  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          enter_disp;
  logic          boundary;
  logic          copy;
  logic          boot;
  logic          en_cur, en_nxt;

  logic [31:0]   act_data, act_data_nxt;
  logic [7:0]    act_dp, act_dp_nxt;
  logic [31:0]   pend_data;
  logic [7:0]    pend_dp;

  logic [3:0]    nib_nxt;
  logic [7:0]    seg_nxt;
  logic [7:0]    sw_nxt;
  logic          fd_nxt;

  // BCD to segment pattern (g..a); codes above 9 blank the digit.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Scan state register; reset parks in the last blank cycle of digit 7 so the
  // first edge after reset lands in DISP at digit 0 with the counter at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      idx   <= 3'd7;
      cnt   <= CW'(BLANK_CYC - 1);
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next scan state plus the next values of the registered display outputs.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    cnt_nxt      = cnt + CW'(1);
    enter_disp   = 1'b0;
    case (state)
      DISP: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
        end
      end
      BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          state_nxt  = DISP;
          cnt_nxt    = '0;
          idx_nxt    = idx + 3'd1;
          enter_disp = 1'b1;
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase

    boundary     = enter_disp && (idx == 3'd7);
    copy         = boundary && !wr_ready;
    act_data_nxt = copy ? pend_data : act_data;
    act_dp_nxt   = copy ? pend_dp   : act_dp;
    en_nxt       = enter_disp ? digit_en[idx_nxt] : en_cur;
    nib_nxt      = act_data_nxt[{idx_nxt, 2'b00} +: 4];

    seg_nxt = 8'h00;
    sw_nxt  = 8'hFF;
    if ((state_nxt == DISP) && en_nxt) begin
      seg_nxt = {act_dp_nxt[idx_nxt], decode(nib_nxt)};
      sw_nxt  = ~(8'h01 << idx_nxt);
    end
    fd_nxt = boundary && !boot;
  end

  // Registered display outputs, slot enable and frame-done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_led    <= 8'h00;
      digtal_sw  <= 8'hFF;
      frame_done <= 1'b0;
      en_cur     <= 1'b0;
      boot       <= 1'b1;
    end else begin
      seg_led    <= seg_nxt;
      digtal_sw  <= sw_nxt;
      frame_done <= fd_nxt;
      en_cur     <= en_nxt;
      boot       <= 1'b0;
    end
  end

  // Frame buffers: accept into pending when ready, promote to active at the
  // frame boundary. Ready low means pending holds an undisplayed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_data  <= '0;
      act_dp    <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      wr_ready  <= 1'b1;
    end else begin
      act_data <= act_data_nxt;
      act_dp   <= act_dp_nxt;
      if (copy) begin
        wr_ready <= 1'b1;
      end else if (wr_valid && wr_ready) begin
        pend_data <= wr_data;
        pend_dp   <= dp_in;
        wr_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: directed scenarios plus random traffic, every
// cycle compared against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = CLK_DIV + BLANK_CYC;
  localparam int FRAME     = 8 * SLOT;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic [7:0]  seg_led;
  logic [7:0]  digtal_sw;
  logic        frame_done;

  int asserts = 0;
  int fails   = 0;

  // Reference model state: n counts clock edges since reset release.
  int          n;
  int          mS;
  int          mP;
  bit          mFd;
  bit          mEn;
  bit          mReady;
  bit          lastAcc;
  logic [31:0] mActive;
  logic [7:0]  mActDp;
  logic [31:0] mPend;
  logic [7:0]  mPendDp;

  logic [7:0] decTab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .seg_led    (seg_led),
    .digtal_sw  (digtal_sw),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %02h expected %02h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic modelReset();
    n       = 0;
    mS      = 0;
    mP      = 0;
    mFd     = 0;
    mEn     = 0;
    mReady  = 1;
    lastAcc = 0;
    mActive = '0;
    mActDp  = '0;
    mPend   = '0;
    mPendDp = '0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_sw"},    digtal_sw,         8'hFF);
    checkOutput({tag, "_seg"},   seg_led,           8'h00);
    checkOutput({tag, "_ready"}, {7'b0, wr_ready},  8'h01);
    checkOutput({tag, "_fd"},    {7'b0, frame_done}, 8'h00);
  endtask

  // One clock: sample inputs, advance the model across the edge, compare.
  task automatic applyStimulus();
    logic        v;
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  en;
    bit          bnd;
    bit          acc;
    logic [3:0]  nib;
    logic [7:0]  expSw;
    logic [7:0]  expSeg;
    v  = wr_valid;
    d  = wr_data;
    dp = dp_in;
    en = digit_en;
    @(posedge clk);
    n++;
    mP  = (n - 1) % SLOT;
    mS  = ((n - 1) / SLOT) % 8;
    bnd = ((n - 1) % FRAME) == 0;
    mFd = bnd && (n > 1);
    if (mP == 0) mEn = en[mS];
    acc = v && mReady;
    if (bnd && !mReady) begin
      mActive = mPend;
      mActDp  = mPendDp;
      mReady  = 1;
    end
    if (acc) begin
      mPend   = d;
      mPendDp = dp;
      mReady  = 0;
    end
    lastAcc = acc;
    #1;
    expSw  = 8'hFF;
    expSeg = 8'h00;
    if (mP < CLK_DIV && mEn) begin
      nib    = 4'((mActive >> (4 * mS)) & 32'hF);
      expSw  = 8'hFF ^ 8'(1 << mS);
      expSeg = decTab[nib] | (mActDp[mS] ? 8'h80 : 8'h00);
    end
    checkOutput("digtal_sw",  digtal_sw,          expSw);
    checkOutput("seg_led",    seg_led,            expSeg);
    checkOutput("wr_ready",   {7'b0, wr_ready},   {7'b0, mReady});
    checkOutput("frame_done", {7'b0, frame_done}, {7'b0, mFd});
  endtask

  task automatic writeFrame(input logic [31:0] d, input logic [7:0] dp);
    wr_data  = d;
    dp_in    = dp;
    wr_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      applyStimulus();
      if (lastAcc) break;
    end
    wr_valid = 1'b0;
    checkOutput("write_accept_timeout", {7'b0, lastAcc}, 8'h01);
  endtask

  task automatic runCycles(input int cnt);
    for (int i = 0; i < cnt; i++) applyStimulus();
  endtask

  // Advance until the next edge is a frame boundary.
  task automatic toBoundary();
    for (int i = 0; i < FRAME + 1; i++) begin
      if (n % FRAME == 0) break;
      applyStimulus();
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    dp_in    = '0;
    digit_en = 8'hFF;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle scan, all digits enabled");
    runCycles(2 * FRAME + 5);

    $display("[TB] write 76543210 mid-frame, then a second write while pending is full");
    writeFrame(32'h7654_3210, 8'h01);
    runCycles(3);
    writeFrame(32'h0198_7654, 8'h80);
    runCycles(2 * FRAME);

    $display("[TB] digit_en FE toggled to FF inside slot 0");
    toBoundary();
    digit_en = 8'hFE;
    runCycles(2);
    digit_en = 8'hFF;
    runCycles(FRAME + 2);

    $display("[TB] blank code C on digit 3");
    writeFrame(32'h0000_C000, 8'h00);
    runCycles(2 * FRAME);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      if (!wr_valid && ($urandom_range(0, 3) == 0)) begin
        wr_data  = $urandom();
        dp_in    = 8'($urandom());
        wr_valid = 1'b1;
      end
      if ($urandom_range(0, 6) == 0) digit_en = 8'($urandom());
      applyStimulus();
      if (lastAcc) wr_valid = 1'b0;
    end
    wr_valid = 1'b0;
    digit_en = 8'hFF;
    runCycles(FRAME);

    $display("[TB] reset during digit 5 with pending full");
    toBoundary();
    runCycles(1);
    writeFrame(32'h5555_5555, 8'hFF);
    for (int i = 0; i < FRAME; i++) begin
      if (mS == 5 && mP == 1) break;
      applyStimulus();
    end
    checkOutput("reach_digit5_timeout", 8'(mS), 8'd5);
    checkOutput("pending_full_before_reset", {7'b0, wr_ready}, 8'h00);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkReset("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    runCycles(FRAME + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
